// File: rtl/store_unit_pkg.sv
// Shared types and the address region decode for the store dispatch unit.
// Region bounds arrive as arguments so each instance can set its own map.
package store_unit_pkg;

    typedef enum logic [1:0] {
        BYTE = 2'd0,
        HALF = 2'd1,
        WORD = 2'd2
    } store_width_t;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_BUFFER,
        WAIT_QUEUE,
        WAIT_ACCEPT
    } state_t;

    typedef enum logic [1:0] {
        REGION_BOOT,
        REGION_TIMER,
        REGION_IO,
        REGION_CACHED
    } region_t;

    // Timer wins over the IO range it sits inside.
    function automatic region_t decode_region(
        input logic [63:0] address,
        input logic [63:0] boot_end,
        input logic [63:0] io_end,
        input logic [63:0] timer_start,
        input logic [63:0] timer_end
    );
        if (address < boot_end) return REGION_BOOT;
        if (address >= timer_start && address < timer_end) return REGION_TIMER;
        if (address < io_end) return REGION_IO;
        return REGION_CACHED;
    endfunction

endpackage

// File: rtl/uncached_store_queue.sv
// Posted uncached-store FIFO; the head is offered to the memory
// controller until it reports completion, then popped.
module uncached_store_queue #(
    parameter int unsigned WIDTH = 66,
    parameter int unsigned DEPTH = 4,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    output logic             request,
    output logic [WIDTH-1:0] head,
    input  logic             done,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             wr_en;
    logic             pop;

    assign empty   = (count == '0);
    assign full    = (count == CNT_W'(DEPTH));
    assign request = !empty;
    assign wr_en   = push && !full;
    assign pop     = request && done;
    assign head    = request ? mem[rd_ptr] : '0;

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= push_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count + CNT_W'(wr_en) - CNT_W'(pop);
        end
    end

endmodule

// File: rtl/store_dispatch_unit.sv
// Routes stores to the store buffer, the posted IO queue or the timer.
// Define STU_MISALIGN_CHECK_EN to fault misaligned HALF/WORD stores.
module store_dispatch_unit
    import store_unit_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned IO_DEPTH = 4,
    parameter logic [ADDR_WIDTH-1:0] BOOT_END = 32'h0000_1000,
    parameter logic [ADDR_WIDTH-1:0] IO_END = 32'h0001_0000,
    parameter logic [ADDR_WIDTH-1:0] TIMER_START = 32'h0000_F000,
    parameter logic [ADDR_WIDTH-1:0] TIMER_END = 32'h0000_F010,
    localparam int unsigned CNT_W = $clog2(IO_DEPTH + 1),
    localparam int unsigned PKT_W = DATA_WIDTH + ADDR_WIDTH + 2
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  valid_i,
    output logic                  ready_o,
    input  logic [DATA_WIDTH-1:0] store_data_i,
    input  logic [ADDR_WIDTH-1:0] store_address_i,
    input  logic [1:0]            operation_i,
    output logic                  buf_push_o,
    output logic [PKT_W-1:0]      buf_packet_o,
    input  logic                  buf_full_i,
    output logic                  mem_request_o,
    output logic [DATA_WIDTH-1:0] mem_data_o,
    output logic [ADDR_WIDTH-1:0] mem_address_o,
    output logic [1:0]            mem_width_o,
    input  logic                  mem_done_i,
    output logic                  timer_write_o,
    output logic                  data_valid_o,
    input  logic                  data_accepted_i,
    output logic                  illegal_access_o,
    output logic                  misaligned_o,
    output logic                  cachable_o,
    output logic [CNT_W-1:0]      io_pending_o,
    output logic                  idle_o
);

    typedef struct packed {
        logic [DATA_WIDTH-1:0] data;
        logic [ADDR_WIDTH-1:0] address;
        store_width_t          width;
    } packet_t;

    state_t  state, next_state;
    region_t region;
    packet_t in_pkt, held_pkt, out_pkt, head_pkt;
    logic    misaligned, accept, enq, q_full, q_empty;
    logic    illegal_q, misaligned_q, cachable_q;

    assign in_pkt = '{
        data:    store_data_i,
        address: store_address_i,
        width:   store_width_t'(operation_i)
    };
    assign region = decode_region(64'(store_address_i), 64'(BOOT_END),
                                  64'(IO_END), 64'(TIMER_START), 64'(TIMER_END));
    assign accept = valid_i && ready_o;

`ifdef STU_MISALIGN_CHECK_EN
    always_comb begin
        misaligned = 1'b0;
        case (store_width_t'(operation_i))
            HALF:    misaligned = store_address_i[0];
            WORD:    misaligned = |store_address_i[1:0];
            default: misaligned = 1'b0;
        endcase
    end
`else
    assign misaligned = 1'b0;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) state <= IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        unique case (state)
            IDLE: begin
                if (valid_i) begin
                    if (region == REGION_BOOT || misaligned) next_state = WAIT_ACCEPT;
                    else if (region == REGION_TIMER)          next_state = WAIT_ACCEPT;
                    else if (region == REGION_IO)             next_state = q_full ? WAIT_QUEUE : WAIT_ACCEPT;
                    else                                      next_state = buf_full_i ? WAIT_BUFFER : WAIT_ACCEPT;
                end
            end
            WAIT_BUFFER: if (!buf_full_i) next_state = WAIT_ACCEPT;
            WAIT_QUEUE:  if (!q_full) next_state = WAIT_ACCEPT;
            WAIT_ACCEPT: if (data_accepted_i) next_state = IDLE;
            default:     next_state = IDLE;
        endcase
    end

    // In IDLE the side effect uses the live inputs; later states replay the held copy.
    always_comb begin
        ready_o       = 1'b0;
        buf_push_o    = 1'b0;
        timer_write_o = 1'b0;
        enq           = 1'b0;
        data_valid_o  = 1'b0;
        out_pkt       = held_pkt;
        unique case (state)
            IDLE: begin
                ready_o = 1'b1;
                out_pkt = in_pkt;
                if (valid_i && region != REGION_BOOT && !misaligned) begin
                    timer_write_o = (region == REGION_TIMER);
                    enq           = (region == REGION_IO) && !q_full;
                    buf_push_o    = (region == REGION_CACHED) && !buf_full_i;
                end
            end
            WAIT_BUFFER: buf_push_o = !buf_full_i;
            WAIT_QUEUE:  enq = !q_full;
            WAIT_ACCEPT: data_valid_o = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            held_pkt     <= '0;
            illegal_q    <= 1'b0;
            misaligned_q <= 1'b0;
            cachable_q   <= 1'b0;
        end else if (accept) begin
            held_pkt     <= in_pkt;
            illegal_q    <= (region == REGION_BOOT);
            misaligned_q <= (region != REGION_BOOT) && misaligned;
            cachable_q   <= (region == REGION_CACHED) && !misaligned;
        end
    end

    uncached_store_queue #(
        .WIDTH (PKT_W),
        .DEPTH (IO_DEPTH)
    ) u_queue (
        .clk       (clk_i),
        .rst       (rst_i),
        .push      (enq),
        .push_data (out_pkt),
        .request   (mem_request_o),
        .head      (head_pkt),
        .done      (mem_done_i),
        .count     (io_pending_o),
        .full      (q_full),
        .empty     (q_empty)
    );

    assign buf_packet_o     = buf_push_o ? out_pkt : '0;
    assign mem_data_o       = head_pkt.data;
    assign mem_address_o    = head_pkt.address;
    assign mem_width_o      = head_pkt.width;
    assign illegal_access_o = data_valid_o && illegal_q;
    assign misaligned_o     = data_valid_o && misaligned_q;
    assign cachable_o       = cachable_q;
    assign idle_o           = (state == IDLE) && q_empty;

endmodule

// File: tb/tb_store_dispatch_unit.sv
// Directed bench for store_dispatch_unit: buffer, IO queue, timer,
// protection, alignment and reset behaviour with hand-computed values.
module tb_store_dispatch_unit;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        valid_i;
    logic        ready_o;
    logic [31:0] store_data_i;
    logic [31:0] store_address_i;
    logic [1:0]  operation_i;
    logic        buf_push_o;
    logic [65:0] buf_packet_o;
    logic        buf_full_i;
    logic        mem_request_o;
    logic [31:0] mem_data_o;
    logic [31:0] mem_address_o;
    logic [1:0]  mem_width_o;
    logic        mem_done_i;
    logic        timer_write_o;
    logic        data_valid_o;
    logic        data_accepted_i;
    logic        illegal_access_o;
    logic        misaligned_o;
    logic        cachable_o;
    logic [2:0]  io_pending_o;
    logic        idle_o;

    int checks = 0;
    int errors = 0;

    store_dispatch_unit dut (
        .clk_i            (clk_i),
        .rst_i            (rst_i),
        .valid_i          (valid_i),
        .ready_o          (ready_o),
        .store_data_i     (store_data_i),
        .store_address_i  (store_address_i),
        .operation_i      (operation_i),
        .buf_push_o       (buf_push_o),
        .buf_packet_o     (buf_packet_o),
        .buf_full_i       (buf_full_i),
        .mem_request_o    (mem_request_o),
        .mem_data_o       (mem_data_o),
        .mem_address_o    (mem_address_o),
        .mem_width_o      (mem_width_o),
        .mem_done_i       (mem_done_i),
        .timer_write_o    (timer_write_o),
        .data_valid_o     (data_valid_o),
        .data_accepted_i  (data_accepted_i),
        .illegal_access_o (illegal_access_o),
        .misaligned_o     (misaligned_o),
        .cachable_o       (cachable_o),
        .io_pending_o     (io_pending_o),
        .idle_o           (idle_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present a store on the next falling edge and settle combinational outputs.
    task automatic drive(input logic [31:0] a, input logic [31:0] d, input logic [1:0] op);
        @(negedge clk_i);
        valid_i = 1'b1;
        store_address_i = a;
        store_data_i = d;
        operation_i = op;
        #1;
    endtask

    task automatic tick();
        @(negedge clk_i);
        valid_i = 1'b0;
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_i = 1'b1;
        valid_i = 1'b0;
        store_data_i = '0;
        store_address_i = '0;
        operation_i = 2'd0;
        buf_full_i = 1'b0;
        mem_done_i = 1'b0;
        data_accepted_i = 1'b0;
        repeat (2) @(negedge clk_i);
        #1;
        chk("rst_ready", ready_o, 1);
        chk("rst_idle", idle_o, 1);
        chk("rst_pending", io_pending_o, 0);
        chk("rst_req", mem_request_o, 0);
        chk("rst_valid", data_valid_o, 0);
        chk("rst_cachable", cachable_o, 0);
        chk("rst_push", buf_push_o, 0);
        rst_i = 1'b0;

        // Cached WORD store, buffer free
        drive(32'h0002_0000, 32'hDEAD_BEEF, 2'd2);
        chk("t1_push", buf_push_o, 1);
        chk("t1_packet", buf_packet_o, {32'hDEAD_BEEF, 32'h0002_0000, 2'b10});
        tick();
        chk("t1_valid", data_valid_o, 1);
        chk("t1_cachable", cachable_o, 1);
        chk("t1_nopush", buf_push_o, 0);
        data_accepted_i = 1'b1;
        tick();
        chk("t1_ready_again", ready_o, 1);
        chk("t1_valid_drop", data_valid_o, 0);

        // Buffer full for three cycles
        buf_full_i = 1'b1;
        drive(32'h0003_0004, 32'h1122_3344, 2'd2);
        chk("t2_acc_nopush", buf_push_o, 0);
        tick();
        store_address_i = '0;
        store_data_i = '0;
        chk("t2_wait1_nopush", buf_push_o, 0);
        chk("t2_wait1_ready", ready_o, 0);
        tick();
        chk("t2_wait2_nopush", buf_push_o, 0);
        tick();
        buf_full_i = 1'b0;
        #1;
        chk("t2_push", buf_push_o, 1);
        chk("t2_packet", buf_packet_o, {32'h1122_3344, 32'h0003_0004, 2'b10});
        chk("t2_novalid", data_valid_o, 0);
        tick();
        chk("t2_valid", data_valid_o, 1);
        chk("t2_single_push", buf_push_o, 0);

        // Five IO stores into a four-entry queue
        for (int i = 1; i <= 4; i++) begin
            drive(32'h0000_2000, 32'(i), 2'd2);
            chk("t3_io_nopush", buf_push_o, 0);
            tick();
            chk("t3_io_valid", data_valid_o, 1);
        end
        chk("t3_pending4", io_pending_o, 4);
        chk("t3_req", mem_request_o, 1);
        chk("t3_head_data", mem_data_o, 1);
        chk("t3_head_addr", mem_address_o, 32'h0000_2000);
        chk("t3_head_width", mem_width_o, 2);
        chk("t3_not_cachable", cachable_o, 0);
        drive(32'h0000_2000, 32'd5, 2'd2);
        chk("t3_5_accept", ready_o, 1);
        tick();
        chk("t3_wq_novalid", data_valid_o, 0);
        chk("t3_wq_ready", ready_o, 0);
        mem_done_i = 1'b1;
        tick();
        mem_done_i = 1'b0;
        chk("t3_after_pop", io_pending_o, 3);
        chk("t3_head2", mem_data_o, 2);
        chk("t3_wq_still", data_valid_o, 0);
        tick();
        chk("t3_5_valid", data_valid_o, 1);
        chk("t3_pending_again4", io_pending_o, 4);
        for (int k = 2; k <= 5; k++) begin
            chk("t3_drain_order", mem_data_o, k);
            mem_done_i = 1'b1;
            tick();
        end
        chk("t3_empty_req", mem_request_o, 0);
        chk("t3_empty_pending", io_pending_o, 0);
        chk("t3_idle", idle_o, 1);
        tick();
        chk("t3_stray_done", io_pending_o, 0);
        mem_done_i = 1'b0;

        // Write-protected boot region
        drive(32'h0000_0800, 32'h0000_00AA, 2'd2);
        chk("t4_nopush", buf_push_o, 0);
        chk("t4_notimer", timer_write_o, 0);
        tick();
        chk("t4_valid", data_valid_o, 1);
        chk("t4_illegal", illegal_access_o, 1);
        chk("t4_nomis", misaligned_o, 0);
        chk("t4_noreq", mem_request_o, 0);
        chk("t4_pending", io_pending_o, 0);

        // Timer window
        drive(32'h0000_F004, 32'h0000_0055, 2'd2);
        chk("t5_timer", timer_write_o, 1);
        chk("t5_nopush", buf_push_o, 0);
        tick();
        chk("t5_timer_drop", timer_write_o, 0);
        chk("t5_valid", data_valid_o, 1);
        chk("t5_legal", illegal_access_o, 0);
        chk("t5_noqueue", io_pending_o, 0);

        // First address past the timer window is plain IO
        drive(32'h0000_F010, 32'h0000_0066, 2'd0);
        chk("t5b_notimer", timer_write_o, 0);
        tick();
        chk("t5b_queued", io_pending_o, 1);
        chk("t5b_addr", mem_address_o, 32'h0000_F010);
        chk("t5b_width", mem_width_o, 0);
        mem_done_i = 1'b1;
        tick();
        mem_done_i = 1'b0;
        chk("t5b_drained", io_pending_o, 0);

        // Misaligned HALF store
        drive(32'h0002_0001, 32'h0000_BEEF, 2'd1);
`ifdef STU_MISALIGN_CHECK_EN
        chk("t6_nopush", buf_push_o, 0);
        tick();
        chk("t6_valid", data_valid_o, 1);
        chk("t6_misaligned", misaligned_o, 1);
`else
        chk("t6_push", buf_push_o, 1);
        chk("t6_packet", buf_packet_o, {32'h0000_BEEF, 32'h0002_0001, 2'b01});
        tick();
        chk("t6_valid", data_valid_o, 1);
        chk("t6_nomis", misaligned_o, 0);
        chk("t6_cachable", cachable_o, 1);
`endif

        // Reset with two queued stores and a pending result
        drive(32'h0000_3000, 32'd7, 2'd2);
        tick();
        drive(32'h0000_3004, 32'd8, 2'd2);
        data_accepted_i = 1'b0;
        tick();
        chk("t7_pending2", io_pending_o, 2);
        chk("t7_req_pre", mem_request_o, 1);
        chk("t7_valid_pre", data_valid_o, 1);
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        chk("t7_pending0", io_pending_o, 0);
        chk("t7_req_drop", mem_request_o, 0);
        chk("t7_valid_drop", data_valid_o, 0);
        chk("t7_ready", ready_o, 1);
        chk("t7_idle", idle_o, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
